// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// fetch_unit : instruction fetch stage with IF/ID register and redirect drain
// Revision   : 1.0
// ============================================================================
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        StallD,
   input  logic        BranchD,
   input  logic        equalD,
   input  logic [31:0] PCBranchD,
   input  logic        JumpD,
   input  logic [31:0] PCJumpD,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] InstrD,
   output logic [31:0] PCPlus4D,
   output logic        ValidD
);

   typedef enum logic [1:0] {
      S_RUN   = 2'd0,
      S_HOLD  = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pcf_q, pcf_d;
   logic [31:0] req_addr_q, req_addr_d;
   logic [31:0] buf_q, buf_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc4_q, pc4_d;
   logic        valid_q, valid_d;

   logic        w_redirect;
   logic [31:0] w_target;
   logic [31:0] w_req_plus4;

   assign w_redirect  = ~StallD & (JumpD | (BranchD & equalD));
   assign w_target    = JumpD ? PCJumpD : PCBranchD;
   assign w_req_plus4 = req_addr_q + 32'd4;

   assign imem_req  = (state_q != S_HOLD);
   assign imem_addr = req_addr_q;
   assign InstrD    = instr_q;
   assign PCPlus4D  = pc4_q;
   assign ValidD    = valid_q;

   always_comb begin
      state_d    = state_q;
      pcf_d      = pcf_q;
      req_addr_d = req_addr_q;
      buf_d      = buf_q;
      instr_d    = instr_q;
      pc4_d      = pc4_q;
      valid_d    = valid_q;

      case (state_q)
         S_RUN: begin
            if (imem_ready) begin
               if (w_redirect) begin
                  pcf_d      = w_target;
                  req_addr_d = w_target;
                  instr_d    = 32'd0;
                  pc4_d      = 32'd0;
                  valid_d    = 1'b0;
               end else if (StallD) begin
                  buf_d   = imem_rdata;
                  state_d = S_HOLD;
               end else begin
                  instr_d    = imem_rdata;
                  pc4_d      = w_req_plus4;
                  valid_d    = 1'b1;
                  pcf_d      = w_req_plus4;
                  req_addr_d = w_req_plus4;
               end
            end else begin
               // The in-flight request must still complete; DRAIN swallows it.
               if (w_redirect) begin
                  pcf_d   = w_target;
                  instr_d = 32'd0;
                  pc4_d   = 32'd0;
                  valid_d = 1'b0;
                  state_d = S_DRAIN;
               end else if (!StallD) begin
                  instr_d = 32'd0;
                  valid_d = 1'b0;
               end
            end
         end

         S_HOLD: begin
            if (w_redirect) begin
               pcf_d      = w_target;
               req_addr_d = w_target;
               instr_d    = 32'd0;
               pc4_d      = 32'd0;
               valid_d    = 1'b0;
               state_d    = S_RUN;
            end else if (!StallD) begin
               instr_d    = buf_q;
               pc4_d      = w_req_plus4;
               valid_d    = 1'b1;
               pcf_d      = w_req_plus4;
               req_addr_d = w_req_plus4;
               state_d    = S_RUN;
            end
         end

         S_DRAIN: begin
            if (w_redirect) begin
               pcf_d   = w_target;
               instr_d = 32'd0;
               pc4_d   = 32'd0;
               valid_d = 1'b0;
            end else if (!StallD) begin
               instr_d = 32'd0;
               valid_d = 1'b0;
            end
            if (imem_ready) begin
               req_addr_d = w_redirect ? w_target : pcf_q;
               state_d    = S_RUN;
            end
         end

         default: state_d = S_RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_RUN;
         pcf_q      <= RESET_PC;
         req_addr_q <= RESET_PC;
         buf_q      <= 32'd0;
         instr_q    <= 32'd0;
         pc4_q      <= 32'd0;
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         pcf_q      <= pcf_d;
         req_addr_q <= req_addr_d;
         buf_q      <= buf_d;
         instr_q    <= instr_d;
         pc4_q      <= pc4_d;
         valid_q    <= valid_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// tb_fetch_unit : table-driven bench for fetch_unit with delivery scoreboard
// Revision      : 1.0
// ============================================================================
module tb_fetch_unit;

   localparam logic [31:0] RPC = 32'h0040_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        StallD = 1'b0, BranchD = 1'b0, equalD = 1'b0, JumpD = 1'b0;
   logic [31:0] PCBranchD = 32'd0, PCJumpD = 32'd0;
   logic        imem_req, imem_ready = 1'b0;
   logic [31:0] imem_addr, imem_rdata = 32'd0;
   logic [31:0] InstrD, PCPlus4D;
   logic        ValidD;

   int checks   = 0;
   int failures = 0;

   fetch_unit #(.RESET_PC(RPC)) dut (
      .clk(clk), .rst_n(rst_n), .StallD(StallD), .BranchD(BranchD), .equalD(equalD),
      .PCBranchD(PCBranchD), .JumpD(JumpD), .PCJumpD(PCJumpD),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
      .imem_rdata(imem_rdata), .InstrD(InstrD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        stall, branch, eq, jump, ready;
      logic [31:0] rdata, pcb, pcj;
      logic        exp_req;
      logic [31:0] exp_addr, exp_instr;
      logic        exp_valid;
      logic [31:0] exp_pc4;
   } vec_t;

   typedef struct {
      logic [31:0] instr, pc4;
   } del_t;

   vec_t vecs[$];
   del_t sb[$];

   function automatic vec_t mk(logic st, logic br, logic eq, logic jp, logic rdy,
                               logic [31:0] rd, logic [31:0] pcb, logic [31:0] pcj,
                               logic ereq, logic [31:0] eaddr, logic [31:0] einstr,
                               logic evalid, logic [31:0] epc4);
      vec_t v;
      v.stall = st; v.branch = br; v.eq = eq; v.jump = jp; v.ready = rdy;
      v.rdata = rd; v.pcb = pcb; v.pcj = pcj;
      v.exp_req = ereq; v.exp_addr = eaddr; v.exp_instr = einstr;
      v.exp_valid = evalid; v.exp_pc4 = epc4;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      StallD = v.stall; BranchD = v.branch; equalD = v.eq; JumpD = v.jump;
      imem_ready = v.ready; imem_rdata = v.rdata; PCBranchD = v.pcb; PCJumpD = v.pcj;
   endtask

   task automatic idle(input logic rdy, input logic [31:0] rd);
      StallD = 1'b0; BranchD = 1'b0; equalD = 1'b0; JumpD = 1'b0;
      PCBranchD = 32'd0; PCJumpD = 32'd0; imem_ready = rdy; imem_rdata = rd;
   endtask

   initial begin
      del_t d;
      //        st br eq jp rdy rdata          pcb            pcj            req addr           instr          v  pc4
      vecs.push_back(mk(0,0,0,0,1, 32'h1111_0000, 0,             0,             1, 32'h0040_0000, 32'h1111_0000, 1, 32'h0040_0004));
      vecs.push_back(mk(0,0,0,0,1, 32'h1111_0001, 0,             0,             1, 32'h0040_0004, 32'h1111_0001, 1, 32'h0040_0008));
      vecs.push_back(mk(0,0,0,0,1, 32'h1111_0002, 0,             0,             1, 32'h0040_0008, 32'h1111_0002, 1, 32'h0040_000C));
      vecs.push_back(mk(0,0,0,0,1, 32'h1111_0003, 0,             0,             1, 32'h0040_000C, 32'h1111_0003, 1, 32'h0040_0010));
      // stall while a word returns, HOLD ignores imem_ready, then release
      vecs.push_back(mk(1,0,0,0,1, 32'h8C01_0004, 0,             0,             1, 32'h0040_0010, 32'h1111_0003, 1, 32'h0040_0010));
      vecs.push_back(mk(1,0,0,0,1, 32'hDEAD_BEEF, 0,             0,             0, 32'h0040_0010, 32'h1111_0003, 1, 32'h0040_0010));
      vecs.push_back(mk(1,0,0,0,0, 32'hDEAD_BEEF, 0,             0,             0, 32'h0040_0010, 32'h1111_0003, 1, 32'h0040_0010));
      vecs.push_back(mk(0,0,0,0,1, 32'hDEAD_BEE1, 0,             0,             0, 32'h0040_0010, 32'h8C01_0004, 1, 32'h0040_0014));
      vecs.push_back(mk(0,0,0,0,0, 32'hDEAD_BEE2, 0,             0,             1, 32'h0040_0014, 32'h0000_0000, 0, 32'h0040_0014));
      // taken branch with ready data
      vecs.push_back(mk(0,1,1,0,1, 32'hBAD0_0001, 32'h0040_0100, 0,             1, 32'h0040_0014, 32'h0000_0000, 0, 32'h0000_0000));
      vecs.push_back(mk(0,0,0,0,1, 32'h2222_0000, 0,             0,             1, 32'h0040_0100, 32'h2222_0000, 1, 32'h0040_0104));
      // branch under stall is ignored
      vecs.push_back(mk(1,1,1,0,0, 32'hBAD0_0002, 32'h0040_0300, 0,             1, 32'h0040_0104, 32'h2222_0000, 1, 32'h0040_0104));
      vecs.push_back(mk(0,0,0,0,1, 32'h3333_0000, 0,             0,             1, 32'h0040_0104, 32'h3333_0000, 1, 32'h0040_0108));
      // jump beats branch
      vecs.push_back(mk(0,1,1,1,1, 32'hBAD0_0003, 32'h0040_0600, 32'h0040_0500, 1, 32'h0040_0108, 32'h0000_0000, 0, 32'h0000_0000));
      vecs.push_back(mk(0,0,0,0,1, 32'h4444_0000, 0,             0,             1, 32'h0040_0500, 32'h4444_0000, 1, 32'h0040_0504));
      // redirect with pending response -> DRAIN, late word discarded
      vecs.push_back(mk(0,1,1,0,0, 32'hBAD0_0004, 32'h0040_0200, 0,             1, 32'h0040_0504, 32'h0000_0000, 0, 32'h0000_0000));
      vecs.push_back(mk(0,0,0,0,0, 32'hBAD0_0005, 0,             0,             1, 32'h0040_0504, 32'h0000_0000, 0, 32'h0000_0000));
      vecs.push_back(mk(0,0,0,0,1, 32'hBAD0_0006, 0,             0,             1, 32'h0040_0504, 32'h0000_0000, 0, 32'h0000_0000));
      vecs.push_back(mk(0,0,0,0,1, 32'h5555_0000, 0,             0,             1, 32'h0040_0200, 32'h5555_0000, 1, 32'h0040_0204));
      // second redirect while draining: newest target wins
      vecs.push_back(mk(0,0,0,1,0, 32'hBAD0_0007, 0,             32'h0040_0700, 1, 32'h0040_0204, 32'h0000_0000, 0, 32'h0000_0000));
      vecs.push_back(mk(0,0,0,1,0, 32'hBAD0_0008, 0,             32'h0040_0800, 1, 32'h0040_0204, 32'h0000_0000, 0, 32'h0000_0000));
      vecs.push_back(mk(0,0,0,0,1, 32'hBAD0_0009, 0,             0,             1, 32'h0040_0204, 32'h0000_0000, 0, 32'h0000_0000));
      vecs.push_back(mk(0,0,0,0,1, 32'h6666_0000, 0,             0,             1, 32'h0040_0800, 32'h6666_0000, 1, 32'h0040_0804));
      // redirect while holding discards the buffer
      vecs.push_back(mk(1,0,0,0,1, 32'hBAD0_000A, 0,             0,             1, 32'h0040_0804, 32'h6666_0000, 1, 32'h0040_0804));
      vecs.push_back(mk(0,0,0,1,1, 32'hBAD0_000B, 0,             32'h0040_0900, 0, 32'h0040_0804, 32'h0000_0000, 0, 32'h0000_0000));
      vecs.push_back(mk(0,0,0,0,1, 32'h7777_0000, 0,             0,             1, 32'h0040_0900, 32'h7777_0000, 1, 32'h0040_0904));
      // 32-bit wrap of the fetch address
      vecs.push_back(mk(0,0,0,1,1, 32'hBAD0_000C, 0,             32'hFFFF_FFFC, 1, 32'h0040_0904, 32'h0000_0000, 0, 32'h0000_0000));
      vecs.push_back(mk(0,0,0,0,1, 32'h8888_0000, 0,             0,             1, 32'hFFFF_FFFC, 32'h8888_0000, 1, 32'h0000_0000));
      vecs.push_back(mk(0,0,0,0,1, 32'h8888_0001, 0,             0,             1, 32'h0000_0000, 32'h8888_0001, 1, 32'h0000_0004));

      // reset state
      #12;
      chk("rst_req",   {31'd0, imem_req}, 32'd1);
      chk("rst_addr",  imem_addr, RPC);
      chk("rst_instr", InstrD, 32'd0);
      chk("rst_pc4",   PCPlus4D, 32'd0);
      chk("rst_valid", {31'd0, ValidD}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i]);
         if (vecs[i].exp_valid && !vecs[i].stall)
            sb.push_back('{vecs[i].exp_instr, vecs[i].exp_pc4});
         #1;
         chk($sformatf("v%0d_req", i),  {31'd0, imem_req}, {31'd0, vecs[i].exp_req});
         chk($sformatf("v%0d_addr", i), imem_addr, vecs[i].exp_addr);
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_instr", i), InstrD, vecs[i].exp_instr);
         chk($sformatf("v%0d_valid", i), {31'd0, ValidD}, {31'd0, vecs[i].exp_valid});
         chk($sformatf("v%0d_pc4", i),   PCPlus4D, vecs[i].exp_pc4);
         if (ValidD && !vecs[i].stall) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL sb_extra: got %h expected no delivery", InstrD);
            end else begin
               d = sb.pop_front();
               chk("sb_instr", InstrD, d.instr);
               chk("sb_pc4", PCPlus4D, d.pc4);
            end
         end
      end
      chk("sb_empty", sb.size(), 32'd0);

      // reset asserted mid-DRAIN
      idle(1'b0, 32'hBAD0_000D);
      JumpD = 1'b1; PCJumpD = 32'h0040_0A00;
      @(posedge clk); #1;
      chk("drain_flush_valid", {31'd0, ValidD}, 32'd0);
      idle(1'b0, 32'hBAD0_000E);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_addr",  imem_addr, RPC);
      chk("arst_req",   {31'd0, imem_req}, 32'd1);
      chk("arst_instr", InstrD, 32'd0);
      chk("arst_pc4",   PCPlus4D, 32'd0);
      imem_ready = 1'b1;
      imem_rdata = 32'hBAD0_000F;
      @(posedge clk); @(posedge clk); #1;
      chk("inrst_valid", {31'd0, ValidD}, 32'd0);
      chk("inrst_instr", InstrD, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      imem_ready = 1'b0;
      #1;
      chk("post_rst_req",  {31'd0, imem_req}, 32'd1);
      chk("post_rst_addr", imem_addr, RPC);
      @(posedge clk); #1;
      chk("post_rst_bubble", {31'd0, ValidD}, 32'd0);
      chk("post_rst_binstr", InstrD, 32'd0);
      idle(1'b1, 32'h9999_0000);
      #1;
      chk("post_rst_addr2", imem_addr, RPC);
      @(posedge clk); #1;
      chk("post_rst_instr", InstrD, 32'h9999_0000);
      chk("post_rst_pc4",   PCPlus4D, RPC + 32'd4);
      chk("post_rst_valid", {31'd0, ValidD}, 32'd1);

      // asynchronous clear of valid IF/ID contents from RUN
      #2;
      rst_n = 1'b0;
      #1;
      chk("arun_valid", {31'd0, ValidD}, 32'd0);
      chk("arun_instr", InstrD, 32'd0);
      chk("arun_addr",  imem_addr, RPC);
      @(negedge clk);
      rst_n = 1'b1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0040_0000: fetch address after reset.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port StallD  input  1  decode stage stalled; IF/ID register holds.
REQ-005 SHALL have port BranchD  input  1  instruction in decode is a conditional branch.
REQ-006 SHALL have port equalD  input  1  branch-taken flag from the decode-stage branch comparator.
REQ-007 SHALL have port PCBranchD  input  32  branch target.
REQ-008 SHALL have port JumpD  input  1  instruction in decode is an unconditional jump.
REQ-009 SHALL have port PCJumpD  input  32  jump target.
REQ-010 SHALL have ports imem_req  output  1 / imem_addr  output  32  instruction memory request and word address.
REQ-011 SHALL have ports imem_ready  input  1 / imem_rdata  input  32  response strobe and instruction word.
REQ-012 SHALL have ports InstrD  output  32 / PCPlus4D  output  32 / ValidD  output  1  IF/ID register contents.

Function
REQ-013 SHALL form redirect = ~StallD & (JumpD | (BranchD & equalD)); target = JumpD ? PCJumpD : PCBranchD (jump priority).
REQ-014 SHALL hold PCF (next fetch PC), ReqAddr (address of outstanding request), 32-bit holding buffer, and 3-state FSM RUN/HOLD/DRAIN.
REQ-015 SHALL drive imem_addr = ReqAddr; imem_req = 1 in RUN and DRAIN, 0 in HOLD; ReqAddr stable while imem_req=1 and imem_ready=0.
REQ-016 RUN, imem_ready=1, no redirect, StallD=0: IF/ID <= {imem_rdata, ReqAddr+4, valid 1}; PCF, ReqAddr <= ReqAddr+4; stay RUN.
REQ-017 RUN, imem_ready=1, StallD=1: buffer <= imem_rdata; IF/ID holds; -> HOLD.
REQ-018 RUN, imem_ready=1, redirect: discard imem_rdata; PCF, ReqAddr <= target; IF/ID flushed; stay RUN.
REQ-019 RUN, imem_ready=0, redirect: PCF <= target; ReqAddr holds; IF/ID flushed; -> DRAIN.
REQ-020 RUN, imem_ready=0, no redirect, StallD=0: IF/ID <= bubble (InstrD 0, ValidD 0, PCPlus4D holds).
REQ-021 HOLD, StallD=0, no redirect: IF/ID <= {buffer, ReqAddr+4, 1}; PCF, ReqAddr <= ReqAddr+4; -> RUN.
REQ-022 HOLD, redirect: discard buffer; PCF, ReqAddr <= target; IF/ID flushed; -> RUN.
REQ-023 DRAIN: imem_ready=1 -> discard data, ReqAddr <= PCF, -> RUN; redirect in DRAIN -> PCF <= newest target, stay DRAIN.
REQ-024 flush SHALL mean InstrD <= 0 (NOP), ValidD <= 0, PCPlus4D <= 0; flush overrides StallD hold.
REQ-025 PC arithmetic SHALL be 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0 with no flag.
REQ-026 imem_ready in HOLD SHALL be ignored.
REQ-027 SHALL never deliver an instruction fetched from a redirected-away path to IF/ID.

Reset
REQ-028 rst_n=0 SHALL immediately force PCF = ReqAddr = RESET_PC, state RUN, buffer 0, InstrD 0, PCPlus4D 0, ValidD 0.
REQ-029 after rst_n rises, first request SHALL be imem_req=1, imem_addr=RESET_PC in that same cycle.
REQ-030 reset asserted mid-request (any state) SHALL abandon the outstanding response; no data from it reaches IF/ID.

Verification
REQ-031 zero-wait memory, no stalls, 4 cycles -> imem_addr 0x400000,04,08,0C; ValidD 1 with PCPlus4D 0x400004.. one cycle later.
REQ-032 StallD=1 for 3 cycles while word 0x8C01_0004 returns -> HOLD, imem_req=0, InstrD unchanged; release -> InstrD=0x8C01_0004 next cycle.
REQ-033 BranchD=1, equalD=1, PCBranchD=0x400100, ready=1 -> InstrD=0, ValidD=0 next cycle; next imem_addr=0x400100.
REQ-034 redirect with imem_ready=0 (2-cycle latency) to 0x400200 -> DRAIN, late word discarded, then imem_addr=0x400200, no stale ValidD=1.
REQ-035 BranchD=1, equalD=1 with StallD=1 -> no redirect, PCF unchanged; JumpD and BranchD together -> target=PCJumpD.
REQ-036 rst_n low mid-DRAIN -> outputs zero asynchronously; imem_addr=RESET_PC; late imem_ready ignored.
